// File: rtl/ncl_pkg.sv
// Shared NULL Convention Logic types and the threshold-gate next-state rule.
package ncl_pkg;

    typedef struct packed {
        logic rail1;
        logic rail0;
    } ncl_dr_t;

    localparam logic [1:0] NCL_NULL    = 2'b00;
    localparam logic [1:0] NCL_DATA0   = 2'b01;
    localparam logic [1:0] NCL_DATA1   = 2'b10;
    localparam logic [1:0] NCL_ILLEGAL = 2'b11;

    // Sets on both inputs high, clears on both low, otherwise holds.
    function automatic logic th22_next(
        input logic a,
        input logic b,
        input logic s
    );
        return (a & b) | (s & (a | b));
    endfunction

endpackage

// File: rtl/ncl_th22_cell.sv
// Single-lane TH22 hysteresis flop: async reset to NULL,
// synchronous clear that forces NULL ahead of the gate rule.
module ncl_th22_cell
    import ncl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_a,
    input  logic i_b,
    output logic o_z
);

    logic r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= 1'b0;
        end else if (i_clr) begin
            r_state <= 1'b0;
        end else begin
            r_state <= th22_next(i_a, i_b, r_state);
        end
    end

    assign o_z = r_state;

endmodule

// File: rtl/ncl_th_gate_bank.sv
// Bank of NCL threshold gates: per lane TH12, TH22 and TH22N,
// plus completeness reductions over TH12 and TH22.
module ncl_th_gate_bank
    import ncl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] th12_z,
    output logic [WIDTH-1:0] th22_z,
    output logic [WIDTH-1:0] th22n_z,
    output logic             all_th12,
    output logic             all_th22
);

    logic [WIDTH-1:0] w_th22;
    logic [WIDTH-1:0] w_th22n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ncl_th22_cell u_th22 (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (1'b0),
            .i_a   (a[i]),
            .i_b   (b[i]),
            .o_z   (w_th22[i])
        );

        // TH22N lanes share the rule but honour the NULL-force.
        ncl_th22_cell u_th22n (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (init),
            .i_a   (a[i]),
            .i_b   (b[i]),
            .o_z   (w_th22n[i])
        );
    end

    assign th12_z   = a | b;
    assign th22_z   = w_th22;
    assign th22n_z  = w_th22n;
    assign all_th12 = &th12_z;
    assign all_th22 = &w_th22;

endmodule

// File: tb/tb_ncl_th_gate_bank.sv
// Scoreboard bench for ncl_th_gate_bank (WIDTH=4): directed
// scenarios followed by randomized traffic against a lane model.
module tb_ncl_th_gate_bank;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] t22;
        logic [W-1:0] t22n;
        logic [W-1:0] t12;
        logic         a12;
        logic         a22;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] th12_z;
    logic [W-1:0] th22_z;
    logic [W-1:0] th22n_z;
    logic         all_th12;
    logic         all_th22;

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    bit   m22[W];
    bit   m22n[W];

    ncl_th_gate_bank #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (init),
        .a        (a),
        .b        (b),
        .th12_z   (th12_z),
        .th22_z   (th22_z),
        .th22n_z  (th22n_z),
        .all_th12 (all_th12),
        .all_th22 (all_th22)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack22();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m22[i];
        return v;
    endfunction

    function automatic logic [W-1:0] pack22n();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m22n[i];
        return v;
    endfunction

    // Lane model: count how many inputs are DATA; two sets, none clears.
    task automatic model_edge(input logic [W-1:0] na, input logic [W-1:0] nb,
                              input logic ni);
        exp_t e;
        int   n;
        for (int i = 0; i < W; i++) begin
            n = int'(na[i]) + int'(nb[i]);
            if (n == 2) m22[i] = 1'b1;
            else if (n == 0) m22[i] = 1'b0;
            if (ni) m22n[i] = 1'b0;
            else if (n == 2) m22n[i] = 1'b1;
            else if (n == 0) m22n[i] = 1'b0;
        end
        e.t22  = pack22();
        e.t22n = pack22n();
        e.t12  = na | nb;
        e.a12  = ((na | nb) == {W{1'b1}});
        e.a22  = (e.t22 == {W{1'b1}});
        q.push_back(e);
    endtask

    task automatic step(input logic [W-1:0] na, input logic [W-1:0] nb,
                        input logic ni);
        @(negedge clk);
        a    = na;
        b    = nb;
        init = ni;
        model_edge(na, nb, ni);
    endtask

    task automatic model_clear();
        for (int i = 0; i < W; i++) begin
            m22[i]  = 1'b0;
            m22n[i] = 1'b0;
        end
    endtask

    // Async reset pulse between edges, optionally with init asserted.
    task automatic reset_pulse(input logic ni);
        @(negedge clk);
        rst_n = 1'b0;
        init  = ni;
        #1;
        model_clear();
        chk("rst_th22", 32'(th22_z), 32'(0));
        chk("rst_th22n", 32'(th22n_z), 32'(0));
        chk("rst_all22", 32'(all_th22), 32'(0));
        chk("rst_th12", 32'(th12_z), 32'(a | b));
        #1;
        rst_n = 1'b1;
        init  = 1'b0;
        model_edge(a, b, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("th22_z", 32'(th22_z), 32'(e.t22));
                chk("th22n_z", 32'(th22n_z), 32'(e.t22n));
                chk("th12_z", 32'(th12_z), 32'(e.t12));
                chk("all_th12", 32'(all_th12), 32'(e.a12));
                chk("all_th22", 32'(all_th22), 32'(e.a22));
            end
        end
    end

    initial begin : stim
        int budget;
        rst_n = 1'b0;
        init  = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        model_clear();
        #2;
        chk("por_th22", 32'(th22_z), 32'(0));
        chk("por_th22n", 32'(th22n_z), 32'(0));
        chk("por_th12", 32'(th12_z), 32'(4'hF));
        repeat (2) @(posedge clk);
        #1;
        chk("hold_rst_th22", 32'(th22_z), 32'(0));
        chk("hold_rst_th22n", 32'(th22n_z), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_edge(a, b, 1'b0);

        step(4'hF, 4'hF, 1'b0);
        step(4'h0, 4'h0, 1'b0);
        step(4'hF, 4'hF, 1'b0);
        repeat (5) step(4'h5, 4'hA, 1'b0);
        step(4'h0, 4'h0, 1'b0);
        repeat (5) step(4'h5, 4'hA, 1'b0);
        step(4'hF, 4'hF, 1'b0);
        step(4'hF, 4'hF, 1'b1);
        step(4'hF, 4'hF, 1'b0);
        step(4'h0, 4'h0, 1'b0);
        step(4'b0011, 4'b0110, 1'b0);
        step(4'hF, 4'hF, 1'b0);
        reset_pulse(1'b1);
        step(4'hF, 4'hF, 1'b0);
        reset_pulse(1'b0);

        for (int k = 0; k < 300; k++) begin
            if (k == 150) begin
                reset_pulse(1'($urandom_range(0, 1)));
            end else begin
                step(4'($urandom), 4'($urandom),
                     ($urandom_range(0, 3) == 0));
            end
        end

        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
